reg_file_sb: RTL
================

Name: reg_file_sb

Overview:
- Parametrised successor of the 16x32 two-read/one-write register file.
  - Width and depth are configurable.
  - Reset is synchronous.
  - Write-to-read bypass is internal.
  - A per-register pending-write scoreboard supports a pipelined datapath.
- Sits between decode (operand read, issue) and write-back in the RISC core.
- Decode stalls on Busy_A/Busy_B.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 16, register count; power of 2, minimum 2.
- ADDR_W, $clog2(NUM_REGS), address width; derived, never overridden.

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  reset; synchronous, active-low.
- Ld  in  1  write enable for write-back.
- C  in  ADDR_W  write address.
- PC  in  DATA_W  write data.
- A  in  ADDR_W  read address, port A.
- B  in  ADDR_W  read address, port B.
- PA  out  DATA_W  read data, port A.
- PB  out  DATA_W  read data, port B.
- Issue  in  1  marks a register as awaiting write-back.
- IssueDst  in  ADDR_W  destination register of the issuing instruction.
- Busy_A  out  1  operand A not yet available.
- Busy_B  out  1  operand B not yet available.
- Pending  out  NUM_REGS  scoreboard vector; bit i set means register i has an outstanding write.

Behaviour:
- Clk is the only clock. Rst_n is synchronous and active-low; it is sampled only on the rising edge of Clk.
- Reset (Rst_n=0 at a rising edge):
  - All registers become 0; Pending becomes 0.
  - Ld and Issue are ignored in that cycle.
  - Reset in mid-operation discards any in-flight pending state.
  - During reset, PA and PB show the pre-reset register contents until the edge, then 0.
- Write: at a rising edge with Rst_n=1 and Ld=1, R[C] <= PC. Latency 1 cycle to storage.
- Read: PA and PB are combinational, 0-cycle latency.
  - PA = PC if Ld=1 and C==A (write-first bypass); otherwise R[A]. PB likewise with B.
  - Both ports may address the same register; both return the same value.
- Scoreboard update, per rising edge with Rst_n=1:
  - If Ld=1, Pending[C] clears.
  - If Issue=1, Pending[IssueDst] sets.
  - If Ld=1 and Issue=1 with C==IssueDst, set wins: Pending stays 1, because a younger producer is now outstanding.
  - Issue to an already-pending register keeps it pending; no count, only a single outstanding write per register is tracked.
  - Ld to a non-pending register writes normally; Pending stays 0; no error.
- Busy outputs:
  - Busy_A = Pending[A] & ~(Ld & C==A).
  - Busy_B = Pending[B] & ~(Ld & C==B).
  - The write-back in the current cycle forwards, so there is no extra stall cycle.
  - Issue in the current cycle does not affect Busy in the same cycle.
- Pending output is the registered vector with no forwarding.
- Address inputs are always in range by construction; there is no wrap-around case.

Optional Feature:
- Macro: REG_FILE_ZERO_R0_EN.
- Defined:
  - Register 0 reads as 0 on PA/PB, including the bypass path.
  - Writes with C=0 are discarded.
  - Issue with IssueDst=0 is ignored; Pending[0] is permanently 0, so Busy is never asserted for address 0.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Package rf_pkg:
  - DATA_W_DEF=32 and NUM_REGS_DEF=16.
  - Typedef reg_addr_t (logic [ADDR_W_DEF-1:0]) and reg_data_t.
  - Reset value constant RF_RST_VAL=0.
- Sub-module rf_scoreboard:
  - Owns Pending, the set/clear priority and Busy_A/Busy_B generation.
  - Ports: Clk, Rst_n, Ld, C, Issue, IssueDst, A, B, Pending, Busy_A, Busy_B.
- The top level holds the storage array and the read/bypass muxing.

Test Plan (DATA_W=32, NUM_REGS=16):
1. Load Ld=1 with C=i and PC=100+i for i=0..15 over 16 cycles, then sweep A=0..15 and B=15..0 -> PA=100+A and PB=100+B. Without the macro, R0 reads 100; with it, R0 reads 0.
2. Bypass: R10=787; in one cycle drive Ld=1, C=10, PC=939, A=10, B=10 -> PA=PB=939 in that same cycle; after the edge, with Ld=0, PA=939.
3. Scoreboard: Issue with IssueDst=5, then A=5 next cycle -> Busy_A=1 and Pending=16'h0020. Then write-back Ld=1, C=5 with A=5 -> Busy_A=0 in that cycle; after the edge, Pending=0.
4. Simultaneous set/clear: Pending[7]=1; in one cycle drive Ld=1, C=7, Issue=1, IssueDst=7 -> after the edge Pending[7]=1 and R7=PC.
5. Reset mid-operation: Pending=16'h0C00 and R3=4253; drive Rst_n=0 for 1 cycle together with Ld=1, C=3, PC=55 -> after the edge R3=0, Pending=0, and A=3 gives PA=0.
6. Width/depth sweep: DATA_W=64, NUM_REGS=32: write 64'hDEAD_BEEF_0123_4567 to R31 -> PA=64'hDEAD_BEEF_0123_4567 with A=31; Issue to 31 then Pending[31]=1.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package rf_pkg;
    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 16;
    localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

    localparam reg_data_t RF_RST_VAL = '0;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write tracker with same-cycle write-back forwarding on Busy.
// REG_FILE_ZERO_R0_EN pins Pending[0] to 0.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int NUM_REGS = NUM_REGS_DEF,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Ld,
    input  logic [ADDR_W-1:0]   C,
    input  logic                Issue,
    input  logic [ADDR_W-1:0]   IssueDst,
    input  logic [ADDR_W-1:0]   A,
    input  logic [ADDR_W-1:0]   B,
    output logic [NUM_REGS-1:0] Pending,
    output logic                Busy_A,
    output logic                Busy_B
);
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Set is applied after clear: a younger producer outranks the retiring one.
    always_comb begin
        pending_d = pending_q;
        if (Ld) begin
            pending_d[C] = 1'b0;
        end
        if (Issue) begin
            pending_d[IssueDst] = 1'b1;
        end
`ifdef REG_FILE_ZERO_R0_EN
        pending_d[0] = 1'b0;
`endif
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign Pending = pending_q;
    assign Busy_A  = pending_q[A] & ~(Ld && (C == A));
    assign Busy_B  = pending_q[B] & ~(Ld && (C == B));
endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with write-first bypass and pending-write scoreboard.
// REG_FILE_ZERO_R0_EN makes register 0 a hard-wired zero.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int NUM_REGS = NUM_REGS_DEF,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Ld,
    input  logic [ADDR_W-1:0]   C,
    input  logic [DATA_W-1:0]   PC,
    input  logic [ADDR_W-1:0]   A,
    input  logic [ADDR_W-1:0]   B,
    output logic [DATA_W-1:0]   PA,
    output logic [DATA_W-1:0]   PB,
    input  logic                Issue,
    input  logic [ADDR_W-1:0]   IssueDst,
    output logic                Busy_A,
    output logic                Busy_B,
    output logic [NUM_REGS-1:0] Pending
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              wr_en;

`ifdef REG_FILE_ZERO_R0_EN
    assign wr_en = Ld && (C != '0);
`else
    assign wr_en = Ld;
`endif

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= DATA_W'(RF_RST_VAL);
            end
        end else if (wr_en) begin
            regs_q[C] <= PC;
        end
    end

    // Bypass keys off wr_en so a discarded R0 write never leaks onto a read port.
    always_comb begin
        PA = regs_q[A];
        PB = regs_q[B];
        if (wr_en && (C == A)) begin
            PA = PC;
        end
        if (wr_en && (C == B)) begin
            PB = PC;
        end
`ifdef REG_FILE_ZERO_R0_EN
        if (A == '0) begin
            PA = '0;
        end
        if (B == '0) begin
            PB = '0;
        end
`endif
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Ld       (Ld),
        .C        (C),
        .Issue    (Issue),
        .IssueDst (IssueDst),
        .A        (A),
        .B        (B),
        .Pending  (Pending),
        .Busy_A   (Busy_A),
        .Busy_B   (Busy_B)
    );
endmodule
